mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported memory bus between the core's fetch port (I) and memory_access port (D).
//  Sits between core and memory; converts the I/D req/ack handshakes into one serialized bus transaction.
//  D has priority, bounded by an I-starvation limit.
//  Exposes i_ack/d_ack so fetch and memory_access can stall their pipeline stages until their access completes.
// PARAMETERS
//  ADDR_W        32   address width, all ports
//  DATA_W        32   data width, all ports
//  STARVE_LIMIT  4    max consecutive D grants while i_req pending (range 1..15)
//  TIMEOUT_CYC   64   bus wait limit in cycles; used only with MEM_ARB_TIMEOUT_EN
// PORTS
//  clk      in   1         clock, rising edge
//  rst_n    in   1         reset, asynchronous, active-low
//  i_req    in   1         fetch request; held with i_addr until i_ack
//  i_addr   in   ADDR_W    fetch address
//  i_rdata  out  DATA_W    fetch read data; valid while i_ack=1
//  i_ack    out  1         one-cycle fetch completion pulse
//  d_req    in   1         data request; held with d_* inputs until d_ack
//  d_we     in   1         1=write, 0=read
//  d_be     in   DATA_W/8  write byte enables
//  d_addr   in   ADDR_W    data address
//  d_wdata  in   DATA_W    write data
//  d_rdata  out  DATA_W    read data; valid while d_ack=1 after a read
//  d_ack    out  1         one-cycle data completion pulse
//  m_req    out  1         bus request; high until m_ack (or timeout)
//  m_we     out  1         bus write strobe
//  m_be     out  DATA_W/8  bus byte enables (all ones for fetch)
//  m_addr   out  ADDR_W    bus address
//  m_wdata  out  DATA_W    bus write data
//  m_rdata  in   DATA_W    bus read data; sampled when m_ack=1
//  m_ack    in   1         bus completion; may be high in the first m_req cycle
//  err      out  1         sticky timeout flag (MEM_ARB_TIMEOUT_EN only)
// BEHAVIOUR
//  Reset values: all outputs 0; state IDLE; starvation counter 0.
//  Reset is asynchronous: asserting rst_n mid-transfer drops m_req immediately; the transfer is lost and not acked.
//  Registered outputs only. No combinational path from any input to any output.
//  FSM states: IDLE -> BUS -> RESP -> IDLE.
//  IDLE: arbitrate, latch the winner's fields into m_*, set m_req=1, go to BUS.
//   Winner rules:
//    - d_req alone -> D.
//    - i_req alone -> I.
//    - Both, starvation counter < STARVE_LIMIT -> D.
//    - Both, counter == STARVE_LIMIT -> I.
//   Counter update on each grant:
//    - D grant while i_req=1: counter += 1.
//    - I grant: counter cleared.
//    - D grant while i_req=0: counter cleared.
//  BUS: hold all m_* stable. On m_ack: m_req=0, capture m_rdata, go to RESP.
//  RESP: pulse the winner's ack for exactly 1 cycle with rdata valid; go to IDLE.
//   - D write: d_rdata holds its previous value.
//  The cycle after an ack, a still-high req counts as a new request.
//  Latency: req sampled in cycle N -> m_req in N+1 -> ack in N+2+W, where W = bus wait cycles.
//   Minimum is 2 cycles (m_ack high in the first m_req cycle).
//  m_ack outside BUS is ignored.
//  A request dropped before its ack is a protocol violation; behaviour is undefined.
// CONFIGURATION
//  MEM_ARB_TIMEOUT_EN defined:
//   - A wait counter runs in BUS.
//   - After TIMEOUT_CYC cycles without m_ack: m_req=0, go to RESP.
//   - The winner's ack pulses with rdata = 0xDEAD_BEEF; err set (sticky until reset).
//   - m_ack in the same cycle as the timeout wins: normal completion, no error.
//  MEM_ARB_TIMEOUT_EN undefined: BUS waits indefinitely; err tied 0; wait counter absent.
// TESTING
//  Reset, no requests -> all outputs 0; m_req stays 0 for 20 cycles.
//  i_req, i_addr=0x100, m_ack in first m_req cycle, m_rdata=0x13 -> i_ack at req+2 with i_rdata=0x13; m_be=0xF, m_we=0.
//  i_req and d_req together (d read 0x2000, m_ack after 3 waits) -> D served first, d_ack at +5;
//   then I on the bus; i_ack 1 cycle after its m_ack.
//  STARVE_LIMIT=2, d_req held high with new requests, i_req held -> grant order D,D,I,D,D,I.
//  D write addr 0x40, be=0x3, wdata=0xAABBCCDD -> m_we=1, m_be=0x3 and m_wdata stable until m_ack; d_ack, d_rdata unchanged.
//  MEM_ARB_TIMEOUT_EN, TIMEOUT_CYC=8, m_ack never -> m_req drops after 8 cycles;
//   ack with rdata 0xDEADBEEF; err=1 until rst_n low.
//   rst_n pulsed low mid-BUS -> m_req=0 immediately, no ack.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory bus between fetch (I) and data (D).
// Ports: clk/rst_n, I req/ack, D req/ack, m_* bus, err (MEM_ARB_TIMEOUT_EN).
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT_CYC  = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_ack,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ack,
  output logic                m_req,
  output logic                m_we,
  output logic [DATA_W/8-1:0] m_be,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_ack,
  output logic                err
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t            state;
  state_t            state_nx;
  logic              owner_d;
  logic [3:0]        starve_cnt;
  logic              grant_d;
  logic              grant_i;
  logic              tmo;
  logic              done;
  logic [DATA_W-1:0] rsp_data;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int WC_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WC_W-1:0] WLIM = WC_W'(TIMEOUT_CYC - 1);

  logic [WC_W-1:0] wait_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (state == BUS) begin
      wait_cnt <= wait_cnt + 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  // m_ack in the timeout cycle completes normally.
  assign tmo = (state == BUS) && !m_ack && (wait_cnt == WLIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (tmo) begin
      err <= 1'b1;
    end
  end
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^TIMEOUT_CYC;
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif

  // D wins unless I has been passed over STARVE_LIMIT times in a row.
  always_comb begin
    grant_d = d_req && (!i_req || (starve_cnt < LIM));
    grant_i = i_req && !grant_d;
    done    = (state == BUS) && (m_ack || tmo);
    rsp_data = m_ack ? m_rdata : DATA_W'(32'hDEAD_BEEF);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (grant_d || grant_i) state_nx = BUS;
      BUS:     if (done) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_d    <= 1'b0;
      starve_cnt <= '0;
      m_req      <= 1'b0;
      m_we       <= 1'b0;
      m_be       <= '0;
      m_addr     <= '0;
      m_wdata    <= '0;
      i_ack      <= 1'b0;
      i_rdata    <= '0;
      d_ack      <= 1'b0;
      d_rdata    <= '0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            grant_d: begin
              owner_d    <= 1'b1;
              starve_cnt <= i_req ? starve_cnt + 1'b1 : '0;
              m_req      <= 1'b1;
              m_we       <= d_we;
              m_be       <= d_be;
              m_addr     <= d_addr;
              m_wdata    <= d_wdata;
            end
            grant_i: begin
              owner_d    <= 1'b0;
              starve_cnt <= '0;
              m_req      <= 1'b1;
              m_we       <= 1'b0;
              m_be       <= {BE_W{1'b1}};
              m_addr     <= i_addr;
              m_wdata    <= '0;
            end
            default: ;
          endcase
        end
        BUS: begin
          if (done) begin
            m_req <= 1'b0;
            if (owner_d) begin
              d_ack <= 1'b1;
              // A completed write leaves d_rdata untouched.
              if (!m_we || !m_ack) d_rdata <= rsp_data;
            end else begin
              i_ack   <= 1'b1;
              i_rdata <= rsp_data;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter.
// STARVE_LIMIT=2, TIMEOUT_CYC=8; timeout steps run with MEM_ARB_TIMEOUT_EN.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        m_req;
  logic        m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ack;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(2), .TIMEOUT_CYC(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ack(m_ack), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  logic [31:0] exp_a [6];

  initial begin
    exp_a = '{32'h400, 32'h400, 32'h300, 32'h400, 32'h400, 32'h300};
    rst_n = 1'b0;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
    m_rdata = '0; m_ack = 1'b0;
    #1;
    chk("rst_m_req", 32'(m_req), 0);
    chk("rst_acks", {30'd0, i_ack, d_ack}, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_rdata", i_rdata | d_rdata, 0);
    chk("rst_err", 32'(err), 0);
    tick(); tick();
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("idle_m_req", 32'(m_req), 0);
    end

    // Fetch, zero wait
    i_req = 1'b1; i_addr = 32'h100; m_ack = 1'b1; m_rdata = 32'h13;
    tick();
    chk("f_m_req", 32'(m_req), 1);
    chk("f_m_addr", m_addr, 32'h100);
    chk("f_m_be", 32'(m_be), 32'hF);
    chk("f_m_we", 32'(m_we), 0);
    chk("f_early_ack", 32'(i_ack), 0);
    tick();
    chk("f_i_ack", 32'(i_ack), 1);
    chk("f_i_rdata", i_rdata, 32'h13);
    chk("f_m_req_drop", 32'(m_req), 0);
    i_req = 1'b0; m_ack = 1'b0;
    tick();
    chk("f_ack_pulse", 32'(i_ack), 0);

    // Both together: D read first, 3 waits
    i_req = 1'b1; i_addr = 32'h200;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000; d_be = 4'hF;
    tick();
    chk("b_m_req", 32'(m_req), 1);
    chk("b_m_addr_d", m_addr, 32'h2000);
    tick(); tick(); tick();
    chk("b_hold_req", 32'(m_req), 1);
    chk("b_hold_addr", m_addr, 32'h2000);
    chk("b_no_ack", {30'd0, i_ack, d_ack}, 0);
    m_ack = 1'b1; m_rdata = 32'hCAFE_0001;
    tick();
    chk("b_d_ack", 32'(d_ack), 1);
    chk("b_d_rdata", d_rdata, 32'hCAFE_0001);
    chk("b_i_ack0", 32'(i_ack), 0);
    d_req = 1'b0; m_ack = 1'b0;
    tick();
    chk("b_d_ack_pulse", 32'(d_ack), 0);
    tick();
    chk("b_i_m_req", 32'(m_req), 1);
    chk("b_i_m_addr", m_addr, 32'h200);
    m_ack = 1'b1; m_rdata = 32'h55;
    tick();
    chk("b_i_ack", 32'(i_ack), 1);
    chk("b_i_rdata", i_rdata, 32'h55);
    chk("b_d_rdata_keep", d_rdata, 32'hCAFE_0001);
    i_req = 1'b0; m_ack = 1'b0;
    tick();

    // Starvation order D,D,I,D,D,I
    i_req = 1'b1; i_addr = 32'h300;
    d_req = 1'b1; d_addr = 32'h400; d_we = 1'b0;
    m_ack = 1'b1; m_rdata = 32'h77;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("s_m_req", 32'(m_req), 1);
      chk("s_order", m_addr, exp_a[k]);
      tick(); tick();
    end
    i_req = 1'b0; d_req = 1'b0; m_ack = 1'b0;
    tick();
    chk("s_i_rdata", i_rdata, 32'h77);

    // D write
    d_req = 1'b1; d_we = 1'b1; d_be = 4'h3; d_addr = 32'h40;
    d_wdata = 32'hAABB_CCDD; m_rdata = 32'h9999_9999;
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("w_m_req", 32'(m_req), 1);
      chk("w_m_we", 32'(m_we), 1);
      chk("w_m_be", 32'(m_be), 32'h3);
      chk("w_m_wdata", m_wdata, 32'hAABB_CCDD);
      chk("w_m_addr", m_addr, 32'h40);
      if (k == 2) m_ack = 1'b1;
      tick();
    end
    chk("w_d_ack", 32'(d_ack), 1);
    chk("w_d_rdata", d_rdata, 32'h77);
    d_req = 1'b0; d_we = 1'b0; m_ack = 1'b0;
    tick();
    chk("w_ack_pulse", 32'(d_ack), 0);

`ifdef MEM_ARB_TIMEOUT_EN
    d_req = 1'b1; d_addr = 32'h500; d_be = 4'hF;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("t_m_req", 32'(m_req), 1);
    end
    tick();
    chk("t_m_req_drop", 32'(m_req), 0);
    chk("t_d_ack", 32'(d_ack), 1);
    chk("t_d_rdata", d_rdata, 32'hDEAD_BEEF);
    chk("t_err", 32'(err), 1);
    d_req = 1'b0;
    tick(); tick(); tick();
    chk("t_err_sticky", 32'(err), 1);
`else
    tick();
    chk("no_tmo_err", 32'(err), 0);
`endif

    // Async reset mid-BUS
    d_req = 1'b1; d_addr = 32'h600; d_we = 1'b0;
    tick();
    chk("r_m_req", 32'(m_req), 1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("r_m_req_drop", 32'(m_req), 0);
    chk("r_rdata_clr", d_rdata, 0);
    chk("r_err_clr", 32'(err), 0);
    d_req = 1'b0; m_ack = 1'b1;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("r_no_ack", {30'd0, i_ack, d_ack}, 0);
      chk("r_m_req_idle", 32'(m_req), 0);
    end
    m_ack = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
